// File: rtl/ws2812b_pkg.sv
// Shared types and default timing for the WS2812B single-pixel serial driver.
// Cycle counts assume a 25 MHz clk (40 ns period).
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HIGH = 2'd1,
        SEND_LOW  = 2'd2,
        LATCH     = 2'd3
    } ws_state_t;

    localparam int T0H_CYC    = 10;
    localparam int T1H_CYC    = 20;
    localparam int TBIT_CYC   = 31;
    localparam int TLATCH_CYC = 1300;
    localparam int FRAME_BITS = 24;

    // Wire order is green, red, blue, MSB first.
    function automatic logic [23:0] grb_pack(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812b_bit_gen.sv
// One WS2812B bit cell: a high pulse of T0H/T1H cycles, then low to fill TBIT.
// A start pulse may coincide with done so bits run back to back without a gap.
module ws2812b_bit_gen
    import ws2812b_pkg::*;
#(
    parameter int T0H  = T0H_CYC,
    parameter int T1H  = T1H_CYC,
    parameter int TBIT = TBIT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_bit,
    output logic o_out,
    output logic o_high_done,
    output logic o_done
);

    localparam logic [4:0] C_HI0_LD = 5'(T0H - 1);
    localparam logic [4:0] C_HI1_LD = 5'(T1H - 1);
    localparam logic [4:0] C_LO0_LD = 5'(TBIT - T0H - 1);
    localparam logic [4:0] C_LO1_LD = 5'(TBIT - T1H - 1);

    logic [4:0] r_cnt;
    logic       r_out;
    logic       r_active;
    logic       r_low;
    logic       r_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_out    <= 1'b0;
            r_active <= 1'b0;
            r_low    <= 1'b0;
            r_bit    <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_low    <= 1'b0;
            r_out    <= 1'b1;
            r_bit    <= i_bit;
            r_cnt    <= i_bit ? C_HI1_LD : C_HI0_LD;
        end else if (r_active) begin
            if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end else if (!r_low) begin
                r_low <= 1'b1;
                r_out <= 1'b0;
                r_cnt <= r_bit ? C_LO1_LD : C_LO0_LD;
            end else begin
                r_active <= 1'b0;
                r_low    <= 1'b0;
            end
        end
    end

    assign o_out       = r_out;
    assign o_high_done = r_active & ~r_low & (r_cnt == 5'd0);
    assign o_done      = r_active &  r_low & (r_cnt == 5'd0);

endmodule

// File: rtl/ws2812b_send.sv
// WS2812B pixel driver: captures GRB colour at frame start, sends 24 NRZ bits, then a latch gap.
// Optional `busy` output is enabled by defining WS2812B_BUSY_EN.
//
// state     | meaning
// IDLE      | out low, waiting for E to start a frame
// SEND_HIGH | high part of the current bit
// SEND_LOW  | low remainder of the current bit
// LATCH     | out low for TLATCH cycles after the last bit
module ws2812b_send
    import ws2812b_pkg::*;
#(
    parameter int T0H    = T0H_CYC,
    parameter int T1H    = T1H_CYC,
    parameter int TBIT   = TBIT_CYC,
    parameter int TLATCH = TLATCH_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       E,
    output logic       out
`ifdef WS2812B_BUSY_EN
    ,
    output logic       busy
`endif
);

    localparam logic [10:0] C_LATCH_LD = 11'(TLATCH - 1);
    localparam logic [4:0]  C_LAST_BIT = 5'(FRAME_BITS - 1);

    ws_state_t   r_state;
    logic [23:0] r_shift;
    logic [4:0]  r_idx;
    logic [10:0] r_latch_cnt;

    logic w_start;
    logic w_bit;
    logic w_out;
    logic w_high_done;
    logic w_done;
    logic w_last;

    assign w_last  = (r_idx == C_LAST_BIT);
    assign w_start = ((r_state == IDLE) & E) |
                     ((r_state == SEND_LOW) & w_done & ~w_last);
    // The first bit goes straight from the input so it starts on the sampling edge;
    // the register then holds the remaining bits with the next one at [23].
    assign w_bit   = (r_state == IDLE) ? green[7] : r_shift[23];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_latch_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (E) begin
                        r_shift <= grb_pack(green, red, blue) << 1;
                        r_idx   <= '0;
                        r_state <= SEND_HIGH;
                    end
                end
                SEND_HIGH: begin
                    if (w_high_done) begin
                        r_state <= SEND_LOW;
                    end
                end
                SEND_LOW: begin
                    if (w_done) begin
                        if (w_last) begin
                            r_latch_cnt <= C_LATCH_LD;
                            r_state     <= LATCH;
                        end else begin
                            r_shift <= r_shift << 1;
                            r_idx   <= r_idx + 5'd1;
                            r_state <= SEND_HIGH;
                        end
                    end
                end
                LATCH: begin
                    if (r_latch_cnt == 11'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_latch_cnt <= r_latch_cnt - 11'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ws2812b_bit_gen #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_bit       (w_bit),
        .o_out       (w_out),
        .o_high_done (w_high_done),
        .o_done      (w_done)
    );

    assign out = w_out;

`ifdef WS2812B_BUSY_EN
    assign busy = (r_state != IDLE);
`endif

endmodule

// File: tb/tb_ws2812b_send.sv
// Scoreboard bench for ws2812b_send: a frame-level model pushes expected GRB words,
// a monitor decodes the data line and pops/compares each completed frame.
module tb_ws2812b_send;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic [7:0] red, green, blue;
    logic       out;
`ifdef WS2812B_BUSY_EN
    logic       busy;
`endif

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];
    int model_cnt = 0;
    int frames_done = 0;
    logic [23:0] last_frame = '0;

    ws2812b_send dut (
        .clk   (clk),
        .rst_n (rst_n),
        .red   (red),
        .green (green),
        .blue  (blue),
        .E     (E),
        .out   (out)
`ifdef WS2812B_BUSY_EN
        ,
        .busy  (busy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame model: a frame starts on the edge that sees E high while idle and keeps
    // the driver busy for 24*31 + 1300 = 2044 cycles.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_cnt = 0;
            end else if (model_cnt == 0) begin
                if (E) begin
                    exp_q.push_back({green, red, blue});
                    model_cnt = 2044;
                end
            end else begin
                model_cnt = model_cnt - 1;
            end
        end
    end

    // Monitor: decodes pulse widths into bits and compares finished frames.
    initial begin
        int cyc, hi_len, bit_cnt, last_rise;
        logic prev;
        logic [23:0] sh;
        logic [23:0] want;
        cyc = 0; hi_len = 0; bit_cnt = 0; last_rise = 0; prev = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("reset_out", {31'd0, out}, 32'd0);
                prev = 1'b0; bit_cnt = 0; hi_len = 0;
            end else begin
                if (model_cnt <= 1300)
                    check("low_outside_bits", {31'd0, out}, 32'd0);
`ifdef WS2812B_BUSY_EN
                check("busy", {31'd0, busy}, {31'd0, (model_cnt != 0)});
`endif
                if (out === 1'b1 && !prev) begin
                    if (bit_cnt > 0)
                        check("bit_period", cyc - last_rise, 31);
                    else
                        check("frame_start", model_cnt, 2044);
                    last_rise = cyc;
                    hi_len = 1;
                end else if (out === 1'b1) begin
                    hi_len++;
                end else if (prev) begin
                    checks++;
                    if (hi_len == 20) begin
                        sh = {sh[22:0], 1'b1};
                    end else begin
                        sh = {sh[22:0], 1'b0};
                        if (hi_len != 10) begin
                            errors++;
                            $display("FAIL pulse_width: got %0d cycles, expected 10 or 20 (bit %0d)", hi_len, bit_cnt);
                        end
                    end
                    bit_cnt++;
                    if (bit_cnt == 24) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: got %0h, expected no frame", sh);
                        end else begin
                            want = exp_q.pop_front();
                            check("frame_data", {8'd0, sh}, {8'd0, want});
                        end
                        last_frame = sh;
                        frames_done++;
                        bit_cnt = 0;
                    end
                end
                prev = (out === 1'b1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", {31'd0, (frames_done >= target)}, 32'd1);
    endtask

    task automatic send_pulse(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        @(negedge clk);
        green = g; red = r; blue = b; E = 1'b1;
        @(negedge clk);
        E = 1'b0;
        wait_frames(frames_done + 1, 2200);
        tick(1400);
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, n;
        rst_n = 1'b0; E = 1'b1;
        green = 8'h12; red = 8'h34; blue = 8'h56;

        tick(5);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_rise", {31'd0, out}, 32'd1);
        @(negedge clk);
        E = 1'b0;
        wait_frames(1, 2200);
        tick(1400);
        check("first_frame", {8'd0, last_frame}, 32'h123456);

        send_pulse(8'h00, 8'h00, 8'h00);
        check("all_zero", {8'd0, last_frame}, 32'h000000);
        send_pulse(8'hFF, 8'h00, 8'h00);
        check("grb_order", {8'd0, last_frame}, 32'hFF0000);
        send_pulse(8'h80, 8'h01, 8'hA5);
        check("bitstream", {8'd0, last_frame}, 32'h8001A5);

        // E toggled every 251 cycles with colours moving mid-frame.
        f0 = frames_done;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c % 251 == 0) E = ~E;
            if (c % 97 == 50) begin
                green = 8'(c); red = 8'(c >> 3); blue = 8'(c ^ 8'h5A);
            end
        end
        E = 1'b0;
        n = 0;
        while (model_cnt != 0 && n < 2200) begin
            @(negedge clk);
            n++;
        end
        tick(10);
        check("toggle_frames", frames_done - f0, 3);
        check("queue_drain", exp_q.size(), 0);

        // Reset in the middle of bit 12, then restart with E held.
        @(negedge clk);
        green = 8'hC3; red = 8'h5A; blue = 8'h0F; E = 1'b1;
        n = 0;
        while (out !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("restart_seen_rise", {31'd0, out}, 32'd1);
        repeat (12 * 31 + 2) @(posedge clk);
        #3 check("pre_reset_high", {31'd0, out}, 32'd1);
        rst_n = 1'b0;
        #1 check("async_reset", {31'd0, out}, 32'd0);
        exp_q.delete();
        green = 8'h0F; red = 8'hF0; blue = 8'h3C;
        tick(3);
        f0 = frames_done;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("restart_rise", {31'd0, out}, 32'd1);
        @(negedge clk);
        E = 1'b0;
        wait_frames(f0 + 1, 2200);
        tick(1400);
        check("restart_frame", {8'd0, last_frame}, 32'h0FF03C);
        check("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
